pe_thread_sequencer: RTL and testbench

//  Parametrised multi-thread issue sequencer for a CGRA PE. It replaces the fixed 7-thread counter and per-thread 1-bit PCs.

---
 rtl/pe_thread_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_pe_thread_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pe_thread_sequencer.sv
// Round-robin issue sequencer for a CGRA PE. Each hardware thread owns a PC with max/loop
// wrap plus ignore/qtd slot accounting; the top interleaves threads one slot per cycle.

module pe_thread_ctx #(
  parameter int PC_WIDTH  = 1,
  parameter int IGN_WIDTH = 16,
  parameter int QTD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 slot_i,
  input  logic                 cfg_sel_i,
  input  logic                 cfg_pc_max_we_i,
  input  logic                 cfg_pc_loop_we_i,
  input  logic [PC_WIDTH-1:0]  cfg_pc_i,
  input  logic                 cfg_ignore_we_i,
  input  logic [IGN_WIDTH-1:0] cfg_ignore_i,
  input  logic                 cfg_qtd_we_i,
  input  logic [QTD_WIDTH-1:0] cfg_qtd_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 ignoring_o,
  output logic                 done_o
);
  logic [PC_WIDTH-1:0]  pc_q, pc_d, pc_max_q, pc_max_d, pc_loop_q, pc_loop_d;
  logic [IGN_WIDTH-1:0] ignore_q, ignore_d, ign_cnt_q, ign_cnt_d;
  logic [QTD_WIDTH-1:0] qtd_q, qtd_d, qtd_cnt_q, qtd_cnt_d;
  logic                 done_q, done_d;
  logic                 issue;

  assign issue      = slot_i & ~done_q;
  assign ignoring_o = ign_cnt_q < ignore_q;
  assign pc_o       = pc_q;
  assign done_o     = done_q;

  always_comb begin
    pc_max_d  = pc_max_q;
    pc_loop_d = pc_loop_q;
    ignore_d  = ignore_q;
    qtd_d     = qtd_q;
    pc_d      = pc_q;
    ign_cnt_d = ign_cnt_q;
    qtd_cnt_d = qtd_cnt_q;
    done_d    = done_q;
    if (cfg_sel_i) begin
      if (cfg_pc_max_we_i)  pc_max_d  = cfg_pc_i;
      if (cfg_pc_loop_we_i) pc_loop_d = cfg_pc_i;
      if (cfg_ignore_we_i)  ignore_d  = cfg_ignore_i;
      if (cfg_qtd_we_i)     qtd_d     = cfg_qtd_i;
    end
    if (start_i) begin
      pc_d      = '0;
      ign_cnt_d = '0;
      qtd_cnt_d = '0;
      done_d    = 1'b0;
    end else if (issue) begin
      pc_d = (pc_q == pc_max_q) ? pc_loop_q : pc_q + 1'b1;
      if (ignoring_o)
        ign_cnt_d = ign_cnt_q + 1'b1;
      else if (qtd_q != '0 && qtd_cnt_q < qtd_q)
        qtd_cnt_d = qtd_cnt_q + 1'b1;
      // >= also catches a qtd rewritten below an already-advanced count
      done_d = (qtd_q != '0) && (qtd_cnt_d >= qtd_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_max_q  <= '0;
      pc_loop_q <= '0;
      ignore_q  <= '0;
      qtd_q     <= '0;
      pc_q      <= '0;
      ign_cnt_q <= '0;
      qtd_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      pc_max_q  <= pc_max_d;
      pc_loop_q <= pc_loop_d;
      ignore_q  <= ignore_d;
      qtd_q     <= qtd_d;
      pc_q      <= pc_d;
      ign_cnt_q <= ign_cnt_d;
      qtd_cnt_q <= qtd_cnt_d;
      done_q    <= done_d;
    end
  end
endmodule

module pe_thread_sequencer #(
  parameter int NUM_THREADS = 7,
  parameter int TID_WIDTH   = 3,
  parameter int PC_WIDTH    = 1,
  parameter int IGN_WIDTH   = 16,
  parameter int QTD_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          start,
  input  logic [TID_WIDTH-1:0]          cfg_tid,
  input  logic                          cfg_pc_max_we,
  input  logic                          cfg_pc_loop_we,
  input  logic [PC_WIDTH-1:0]           cfg_pc,
  input  logic                          cfg_ignore_we,
  input  logic [IGN_WIDTH-1:0]          cfg_ignore,
  input  logic                          cfg_qtd_we,
  input  logic [QTD_WIDTH-1:0]          cfg_qtd,
  output logic [TID_WIDTH+PC_WIDTH-1:0] inst_raddr,
  output logic                          issue_valid,
  output logic [TID_WIDTH-1:0]          out_tid,
  output logic                          out_valid,
  output logic [NUM_THREADS-1:0]        thread_done,
  output logic                          done
);
  logic [TID_WIDTH-1:0]                   thread_idx_q, thread_idx_d, out_tid_q, out_tid_d;
  logic                                   out_valid_q, out_valid_d, done_q, done_d;
  logic [NUM_THREADS-1:0][PC_WIDTH-1:0]   pc;
  logic [NUM_THREADS-1:0]                 ignoring;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    pe_thread_ctx #(
      .PC_WIDTH (PC_WIDTH),
      .IGN_WIDTH(IGN_WIDTH),
      .QTD_WIDTH(QTD_WIDTH)
    ) u_ctx (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start),
      .slot_i          (en && thread_idx_q == TID_WIDTH'(t)),
      .cfg_sel_i       (cfg_tid == TID_WIDTH'(t)),
      .cfg_pc_max_we_i (cfg_pc_max_we),
      .cfg_pc_loop_we_i(cfg_pc_loop_we),
      .cfg_pc_i        (cfg_pc),
      .cfg_ignore_we_i (cfg_ignore_we),
      .cfg_ignore_i    (cfg_ignore),
      .cfg_qtd_we_i    (cfg_qtd_we),
      .cfg_qtd_i       (cfg_qtd),
      .pc_o            (pc[t]),
      .ignoring_o      (ignoring[t]),
      .done_o          (thread_done[t])
    );
  end

  assign inst_raddr  = {thread_idx_q, pc[thread_idx_q]};
  assign issue_valid = en & ~thread_done[thread_idx_q];
  assign out_tid     = out_tid_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;

  always_comb begin
    thread_idx_d = thread_idx_q;
    out_tid_d    = out_tid_q;
    out_valid_d  = out_valid_q;
    done_d       = &thread_done;
    if (start) begin
      thread_idx_d = '0;
      out_tid_d    = '0;
      out_valid_d  = 1'b0;
      done_d       = 1'b0;
    end else if (en) begin
      // done threads keep their slot so the interleave stays fixed
      thread_idx_d = (thread_idx_q == TID_WIDTH'(NUM_THREADS-1)) ? '0 : thread_idx_q + 1'b1;
      out_tid_d    = thread_idx_q;
      out_valid_d  = issue_valid & ~ignoring[thread_idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thread_idx_q <= '0;
      out_tid_q    <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      thread_idx_q <= thread_idx_d;
      out_tid_q    <= out_tid_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_pe_thread_sequencer.sv
// Directed bench for pe_thread_sequencer; PC_WIDTH=2 so loop-wrap cases fit.
module tb_pe_thread_sequencer;
  localparam int NT = 7, TW = 3, PW = 2, IW = 16, QW = 32;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0;
  logic [TW-1:0] cfg_tid = '0;
  logic          cfg_pc_max_we = 1'b0, cfg_pc_loop_we = 1'b0, cfg_ignore_we = 1'b0, cfg_qtd_we = 1'b0;
  logic [PW-1:0] cfg_pc = '0;
  logic [IW-1:0] cfg_ignore = '0;
  logic [QW-1:0] cfg_qtd = '0;
  logic [TW+PW-1:0] inst_raddr;
  logic          issue_valid, out_valid, done;
  logic [TW-1:0] out_tid;
  logic [NT-1:0] thread_done;

  int n_chk = 0, n_pass = 0;
  int i;
  int loopexp[7] = '{0, 1, 2, 3, 2, 3, 2};

  pe_thread_sequencer #(.NUM_THREADS(NT), .TID_WIDTH(TW), .PC_WIDTH(PW),
                        .IGN_WIDTH(IW), .QTD_WIDTH(QW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .cfg_tid(cfg_tid),
    .cfg_pc_max_we(cfg_pc_max_we), .cfg_pc_loop_we(cfg_pc_loop_we), .cfg_pc(cfg_pc),
    .cfg_ignore_we(cfg_ignore_we), .cfg_ignore(cfg_ignore), .cfg_qtd_we(cfg_qtd_we),
    .cfg_qtd(cfg_qtd), .inst_raddr(inst_raddr), .issue_valid(issue_valid),
    .out_tid(out_tid), .out_valid(out_valid), .thread_done(thread_done), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] ra(input int tid, input int pc);
    return 64'((tid << PW) | pc);
  endfunction

  task automatic cfg(input int tid, input logic mx, input logic lp, input logic ig, input logic qt,
                     input int pcv, input int igv, input int qtv);
    cfg_tid = TW'(tid); cfg_pc = PW'(pcv); cfg_ignore = IW'(igv); cfg_qtd = QW'(qtv);
    cfg_pc_max_we = mx; cfg_pc_loop_we = lp; cfg_ignore_we = ig; cfg_qtd_we = qt;
    tick();
    cfg_pc_max_we = 0; cfg_pc_loop_we = 0; cfg_ignore_we = 0; cfg_qtd_we = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_raddr", inst_raddr, 0);
    chk("rst_out_tid", out_tid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_thread_done", thread_done, 0);
    chk("rst_done", done, 0);
    chk("rst_issue_en0", issue_valid, 0);
    en = 1'b1; #1;
    chk("rst_issue_en1", issue_valid, 1);
    tick(); rst = 1'b0;

    // round robin after reset, cleared config keeps PCs at 0
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_raddr", inst_raddr, ra(k % 7, 0));
      if (k >= 1) chk("rr_out_valid", out_valid, 1);
      tick();
    end

    // defaults pc_max=1 pc_loop=0
    en = 1'b0;
    for (int t = 0; t < NT; t++) cfg(t, 1, 0, 0, 0, 1, 0, 0);
    pulse_start(); en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1 chk("seq_raddr", inst_raddr, ra(k % 7, (k / 7) % 2));
      tick();
    end

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    chk("arst_raddr", inst_raddr, 0);
    chk("arst_out_tid", out_tid, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_thread_done", thread_done, 0);
    chk("arst_done", done, 0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1 chk("arst_cfg_cleared", inst_raddr, ra(k % 7, 0));
      tick();
    end

    // loop wrap on thread 0
    en = 1'b0;
    cfg(0, 1, 0, 0, 0, 3, 0, 0);
    cfg(0, 0, 1, 0, 0, 2, 0, 0);
    pulse_start(); en = 1'b1;
    for (int s = 0; s < 7; s++) begin
      #1 chk("loop_pc", inst_raddr, ra(0, loopexp[s]));
      repeat (7) tick();
    end

    // thread 2 ignore=2 qtd=3, both written together
    en = 1'b0;
    cfg(2, 0, 0, 1, 1, 0, 2, 3);
    pulse_start(); en = 1'b1;
    tick(); tick();
    for (int k = 0; k < 7; k++) begin
      #1 chk("acc_issue", issue_valid, (k < 5));
      tick();
      chk("acc_out_valid", out_valid, (k >= 2 && k < 5));
      chk("acc_out_tid", out_tid, 2);
      chk("acc_thread_done", thread_done, (k >= 4) ? 7'h04 : 7'h00);
      repeat (6) tick();
    end
    chk("acc_done_low", done, 0);

    // all threads qtd=1: done at cycle 8
    en = 1'b0;
    for (int t = 0; t < NT; t++) cfg(t, 0, 0, 1, 1, 0, 0, 1);
    pulse_start(); en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1 chk("all_done", done, (c >= 8));
      if (c == 7) chk("all_thread_done", thread_done, 7'h7f);
      if (c == 8) chk("all_issue_off", issue_valid, 0);
      tick();
    end

    // en low for 3 cycles mid-run
    en = 1'b0;
    for (int t = 0; t < NT; t++) cfg(t, 0, 1, 1, 1, 0, 0, 0);
    for (int t = 0; t < NT; t++) cfg(t, 1, 0, 0, 0, 1, 0, 0);
    pulse_start();
    i = 0;
    for (int c = 0; c < 13; c++) begin
      en = !(c >= 4 && c < 7);
      #1 chk("hold_raddr", inst_raddr, ra(i % 7, (i / 7) % 2));
      if (en) chk("hold_issue_on", issue_valid, 1);
      else begin
        chk("hold_issue_off", issue_valid, 0);
        chk("hold_out_tid", out_tid, 3);
        chk("hold_out_valid", out_valid, 1);
      end
      tick();
      if (en) i++;
    end

    // out-of-range cfg_tid ignored, then start mid-run
    cfg(7, 1, 1, 1, 1, 3, 5, 1);
    pulse_start();
    #1;
    chk("start_out_valid", out_valid, 0);
    chk("start_thread_done", thread_done, 0);
    chk("start_done", done, 0);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) #1;
      chk("start_raddr", inst_raddr, ra(k % 7, (k / 7) % 2));
      if (k == 1) chk("start_out_valid_run", out_valid, 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
